// File: rtl/dcache_sram_nway.sv
// dcache_sram_nway: N-way set-associative data-cache storage with true-LRU
// replacement, dirty tracking, victim readout and a one-cycle registered
// lookup/write pipeline.
//
// Optional feature macro: DCACHE_SRAM_FLUSH_EN (invalidate sweep + flush ports)
//
// Ports:
//   clk_i, rst_ni         clock (rising edge), async active-low reset
//   req_i / ready_o       request handshake, accepted when req_i && ready_o
//   write_i, dirty_i      0 = lookup / 1 = write; dirty value for writes
//   addr_i, tag_i, data_i set index, request tag, write line
//   valid_o, hit_o        one-cycle result strobe, tag match flag
//   tag_o, data_o         {valid, dirty, tag} and line of hit or victim way
//   flush_i, flush_busy_o invalidate sweep start / in progress (macro only)
module dcache_sram_nway #(
    parameter int unsigned WAYS   = 2,
    parameter int unsigned SETS   = 16,
    parameter int unsigned TAG_W  = 23,
    parameter int unsigned LINE_W = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    output logic                    ready_o,
    input  logic                    write_i,
    input  logic                    dirty_i,
    input  logic [$clog2(SETS)-1:0] addr_i,
    input  logic [TAG_W-1:0]        tag_i,
    input  logic [LINE_W-1:0]       data_i,
    output logic                    valid_o,
    output logic                    hit_o,
    output logic [TAG_W+1:0]        tag_o,
    output logic [LINE_W-1:0]       data_o
`ifdef DCACHE_SRAM_FLUSH_EN
    ,
    input  logic                    flush_i,
    output logic                    flush_busy_o
`endif
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned AGE_W = $clog2(WAYS);

    // Storage: valid/dirty/age are reset, tag/line are not
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [AGE_W-1:0]  age_q   [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [LINE_W-1:0] line_q  [SETS][WAYS];

    logic              accept_c;
    logic              update_c;
    logic              hit_c;
    logic              vic_found_c;
    logic [AGE_W-1:0]  hit_way_c;
    logic [AGE_W-1:0]  vic_way_c;
    logic [AGE_W-1:0]  sel_way_c;
    logic [AGE_W-1:0]  sel_age_c;
    logic [AGE_W-1:0]  age_nxt_c [WAYS];
    logic              sweep_c;
    logic [IDX_W-1:0]  sweep_set_c;

`ifdef DCACHE_SRAM_FLUSH_EN
    typedef enum logic {IDLE, SWEEP} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    // Flush FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Flush FSM next state; a flush request wins over a simultaneous req_i
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ready_o      = 1'b0;
        flush_busy_o = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = !flush_i;
                if (flush_i) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                flush_busy_o = 1'b1;
                cnt_d        = IDX_W'(cnt_q + 1'b1);
                if (cnt_q == IDX_W'(SETS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sweep_c     = (state_q == SWEEP);
    assign sweep_set_c = cnt_q;
`else
    assign ready_o     = 1'b1;
    assign sweep_c     = 1'b0;
    assign sweep_set_c = '0;
`endif

    assign accept_c = req_i && ready_o;
    assign update_c = accept_c && (write_i || hit_c);

    // Tag match, victim choice (lowest invalid, else oldest) and LRU touch
    always_comb begin
        hit_c       = 1'b0;
        hit_way_c   = '0;
        vic_found_c = 1'b0;
        vic_way_c   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[addr_i][w] && (tag_q[addr_i][w] == tag_i)) begin
                hit_c     = 1'b1;
                hit_way_c = AGE_W'(w);
            end
        end
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!vic_found_c && !valid_q[addr_i][w]) begin
                vic_found_c = 1'b1;
                vic_way_c   = AGE_W'(w);
            end
        end
        if (!vic_found_c) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_q[addr_i][w] == AGE_W'(WAYS - 1)) vic_way_c = AGE_W'(w);
            end
        end
        sel_way_c = hit_c ? hit_way_c : vic_way_c;
        sel_age_c = age_q[addr_i][sel_way_c];
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == sel_way_c) begin
                age_nxt_c[w] = '0;
            end else if (age_q[addr_i][w] < sel_age_c) begin
                age_nxt_c[w] = AGE_W'(age_q[addr_i][w] + 1'b1);
            end else begin
                age_nxt_c[w] = age_q[addr_i][w];
            end
        end
    end

    // Control state and registered result
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= AGE_W'(w);
                end
            end
            valid_o <= 1'b0;
            hit_o   <= 1'b0;
            tag_o   <= '0;
            data_o  <= '0;
        end else begin
            valid_o <= accept_c;
            if (accept_c) begin
                hit_o <= hit_c;
                if (write_i && hit_c) begin
                    // Write hit reports the way after the update
                    tag_o  <= {1'b1, dirty_q[addr_i][sel_way_c] | dirty_i, tag_q[addr_i][sel_way_c]};
                    data_o <= data_i;
                end else begin
                    // Lookup, or write miss reporting the victim before overwrite
                    tag_o  <= {valid_q[addr_i][sel_way_c], dirty_q[addr_i][sel_way_c],
                               tag_q[addr_i][sel_way_c]};
                    data_o <= line_q[addr_i][sel_way_c];
                end
            end
            if (update_c) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    age_q[addr_i][w] <= age_nxt_c[w];
                end
                if (write_i) begin
                    valid_q[addr_i][sel_way_c] <= 1'b1;
                    dirty_q[addr_i][sel_way_c] <= hit_c ? (dirty_q[addr_i][sel_way_c] | dirty_i)
                                                        : dirty_i;
                end
            end
            if (sweep_c) begin
                valid_q[sweep_set_c] <= '0;
                dirty_q[sweep_set_c] <= '0;
            end
        end
    end

    // Tag and line payload, not reset
    always_ff @(posedge clk_i) begin
        if (accept_c && write_i) begin
            tag_q[addr_i][sel_way_c]  <= tag_i;
            line_q[addr_i][sel_way_c] <= data_i;
        end
    end

endmodule

// File: tb/tb_dcache_sram_nway.sv
// tb_dcache_sram_nway: randomized scoreboard bench for dcache_sram_nway with a
// recency-list cache model; directed scenarios plus random traffic.
module tb_dcache_sram_nway;

    localparam int unsigned WAYS   = 2;
    localparam int unsigned SETS   = 16;
    localparam int unsigned TAG_W  = 23;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned IDX_W  = $clog2(SETS);

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              req = 1'b0;
    logic              ready;
    logic              write = 1'b0;
    logic              dirty = 1'b0;
    logic [IDX_W-1:0]  addr = '0;
    logic [TAG_W-1:0]  tag = '0;
    logic [LINE_W-1:0] data = '0;
    logic              valid_o;
    logic              hit_o;
    logic [TAG_W+1:0]  tag_o;
    logic [LINE_W-1:0] data_o;
`ifdef DCACHE_SRAM_FLUSH_EN
    logic              flush = 1'b0;
    logic              flush_busy;
`endif

    dcache_sram_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_i        (req),
        .ready_o      (ready),
        .write_i      (write),
        .dirty_i      (dirty),
        .addr_i       (addr),
        .tag_i        (tag),
        .data_i       (data),
        .valid_o      (valid_o),
        .hit_o        (hit_o),
        .tag_o        (tag_o),
        .data_o       (data_o)
`ifdef DCACHE_SRAM_FLUSH_EN
        ,
        .flush_i      (flush),
        .flush_busy_o (flush_busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                hit;
        logic [TAG_W+1:0]  tagv;
        logic [LINE_W-1:0] line;
        bit                full;   // entry valid: compare tag and line too
    } exp_t;

    exp_t sbq[$];
    exp_t e_mon;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: per-way contents plus a recency list per set
    bit                m_valid [SETS][WAYS];
    bit                m_dirty [SETS][WAYS];
    logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
    logic [LINE_W-1:0] m_line  [SETS][WAYS];
    int                m_order [SETS][WAYS];   // index 0 = most recent

    task automatic cmp(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_order[s][w] = w;
            end
    endfunction

    function automatic void touch(input int s, input int w);
        int p = 0;
        for (int i = 0; i < WAYS; i++) if (m_order[s][i] == w) p = i;
        for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
        m_order[s][0] = w;
    endfunction

    function automatic exp_t model_op(input bit wr, input bit dty, input int s,
                                      input logic [TAG_W-1:0] t, input logic [LINE_W-1:0] d);
        exp_t e;
        int   w = -1;
        int   v = -1;
        for (int i = 0; i < WAYS; i++) if (m_valid[s][i] && m_tag[s][i] == t) w = i;
        if (w >= 0) begin
            if (wr) begin
                m_line[s][w]  = d;
                m_dirty[s][w] = m_dirty[s][w] | dty;
            end
            touch(s, w);
            e.hit  = 1'b1;
            e.tagv = {1'b1, m_dirty[s][w], m_tag[s][w]};
            e.line = m_line[s][w];
            e.full = 1'b1;
        end else begin
            for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[s][i]) v = i;
            if (v < 0) v = m_order[s][WAYS-1];
            e.hit  = 1'b0;
            e.tagv = {m_valid[s][v], m_dirty[s][v], m_tag[s][v]};
            e.line = m_line[s][v];
            e.full = m_valid[s][v];
            if (wr) begin
                m_valid[s][v] = 1'b1;
                m_dirty[s][v] = dty;
                m_tag[s][v]   = t;
                m_line[s][v]  = d;
                touch(s, v);
            end
        end
        return e;
    endfunction

    // Monitor: every result strobe pops one expectation
    always @(negedge clk) begin
        if (rst_ni && valid_o) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid actual=1 required=0");
            end else begin
                e_mon = sbq.pop_front();
                cmp("sb_hit", LINE_W'(hit_o), LINE_W'(e_mon.hit));
                if (e_mon.full) begin
                    cmp("sb_tag", LINE_W'(tag_o), LINE_W'(e_mon.tagv));
                    cmp("sb_data", data_o, e_mon.line);
                end else begin
                    cmp("sb_vd", LINE_W'(tag_o[TAG_W+1:TAG_W]), LINE_W'(e_mon.tagv[TAG_W+1:TAG_W]));
                end
            end
        end
    end

    // One request; returns just after its accept edge with the result visible
    task automatic issue(input bit wr, input bit dty, input int s,
                         input logic [TAG_W-1:0] t, input logic [LINE_W-1:0] d);
        @(negedge clk);
        req   = 1'b1;
        write = wr;
        dirty = dty;
        addr  = IDX_W'(s);
        tag   = t;
        data  = d;
        #1;
        if (ready) sbq.push_back(model_op(wr, dty, s, t, d));
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        req    = 1'b0;
`ifdef DCACHE_SRAM_FLUSH_EN
        flush  = 1'b0;
`endif
        sbq.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    logic [LINE_W-1:0] line_a, line_b, line_c;
    int                busy_cnt;

    initial begin
        model_reset();
        #2;
        cmp("rst_valid", LINE_W'(valid_o), '0);
        cmp("rst_hit", LINE_W'(hit_o), '0);
        cmp("rst_tag", LINE_W'(tag_o), '0);
        cmp("rst_data", data_o, '0);
        cmp("rst_ready", LINE_W'(ready), LINE_W'(1'b1));
        idle(2);
        rst_ni = 1'b1;

        // Lookup after reset misses on an invalid victim
        issue(1'b0, 1'b0, 3, TAG_W'(32'h1234), '0);
        cmp("first_hit", LINE_W'(hit_o), '0);
        cmp("first_vbit", LINE_W'(tag_o[TAG_W+1]), '0);

        // Refill, lookup, then store sets dirty
        line_a = {32{8'hAA}};
        issue(1'b1, 1'b0, 3, TAG_W'(32'h1234), line_a);
        issue(1'b0, 1'b0, 3, TAG_W'(32'h1234), '0);
        cmp("refill_hit", LINE_W'(hit_o), LINE_W'(1'b1));
        cmp("refill_tag", LINE_W'(tag_o), LINE_W'({2'b10, TAG_W'(32'h1234)}));
        cmp("refill_data", data_o, line_a);
        issue(1'b1, 1'b1, 3, TAG_W'(32'h1234), rnd_line());
        cmp("store_dirty", LINE_W'(tag_o[TAG_W]), LINE_W'(1'b1));

        // LRU eviction in set 5: A, B, touch A, C evicts B
        line_a = rnd_line();
        line_b = rnd_line();
        line_c = rnd_line();
        issue(1'b1, 1'b0, 5, TAG_W'(32'hA), line_a);
        issue(1'b1, 1'b0, 5, TAG_W'(32'hB), line_b);
        issue(1'b0, 1'b0, 5, TAG_W'(32'hA), '0);
        issue(1'b1, 1'b0, 5, TAG_W'(32'hC), line_c);
        cmp("evict_hit", LINE_W'(hit_o), '0);
        cmp("evict_tag", LINE_W'(tag_o), LINE_W'({2'b10, TAG_W'(32'hB)}));
        cmp("evict_data", data_o, line_b);
        issue(1'b0, 1'b0, 5, TAG_W'(32'hB), '0);
        cmp("evicted_miss", LINE_W'(hit_o), '0);
        issue(1'b0, 1'b0, 5, TAG_W'(32'hA), '0);
        cmp("kept_hit", LINE_W'(hit_o), LINE_W'(1'b1));

        // Back-to-back write then lookup of the same set and tag
        issue(1'b1, 1'b0, 7, TAG_W'(32'h55), rnd_line());
        cmp("b2b_valid0", LINE_W'(valid_o), LINE_W'(1'b1));
        issue(1'b0, 1'b0, 7, TAG_W'(32'h55), '0);
        cmp("b2b_valid1", LINE_W'(valid_o), LINE_W'(1'b1));
        cmp("b2b_hit", LINE_W'(hit_o), LINE_W'(1'b1));
        idle(2);
        cmp("idle_valid", LINE_W'(valid_o), '0);

        // Random traffic over a few sets and a small tag space
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) != 0)
                issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), TAG_W'($urandom_range(0, 4)), rnd_line());
            else
                idle(1);
        end

`ifdef DCACHE_SRAM_FLUSH_EN
        // Flush with a simultaneous request: request refused, SETS busy cycles
        for (int s = 0; s < 4; s++) issue(1'b1, 1'b1, s, TAG_W'(32'h77), rnd_line());
        @(negedge clk);
        flush = 1'b1;
        req   = 1'b1;
        write = 1'b0;
        addr  = '0;
        tag   = TAG_W'(32'h77);
        #1 cmp("flush_ready", LINE_W'(ready), '0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        req   = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < SETS + 4; i++) begin
            @(negedge clk);
            if (flush_busy) busy_cnt++;
        end
        cmp("flush_busy_cycles", LINE_W'(busy_cnt), LINE_W'(SETS));
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        for (int s = 0; s < 4; s++) begin
            issue(1'b0, 1'b0, s, TAG_W'(32'h77), '0);
            cmp("post_flush_miss", LINE_W'(hit_o), '0);
            cmp("post_flush_vd", LINE_W'(tag_o[TAG_W+1:TAG_W]), '0);
        end

        // Reset in the middle of a sweep
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        idle(3);
        rst_ni = 1'b0;
        #1;
        cmp("rst_sweep_busy", LINE_W'(flush_busy), '0);
        apply_reset();
`endif

        // Reset while a result is being presented
        issue(1'b1, 1'b1, 9, TAG_W'(32'h99), rnd_line());
        #1 rst_ni = 1'b0;
        #1 cmp("rst_mid_valid", LINE_W'(valid_o), '0);
        apply_reset();
        issue(1'b0, 1'b0, 9, TAG_W'(32'h99), '0);
        cmp("post_rst_miss9", LINE_W'(hit_o), '0);
        issue(1'b0, 1'b0, 3, TAG_W'(32'h1234), '0);
        cmp("post_rst_miss3", LINE_W'(hit_o), '0);
        cmp("post_rst_vbit", LINE_W'(tag_o[TAG_W+1]), '0);

        idle(3);
        cmp("sb_drain", LINE_W'(sbq.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
